// File: rtl/cpu_fsm_if.sv
// ---------------------------------------------------------------------------
// cpu_fsm_if
// Bundle between the instruction decoder/datapath and the cpu_fsm controller.
//
// Signals:
//   s       start strobe (decoder -> controller)
//   opcode  decoded opcode, 110 = MOV, 101 = ALU (decoder -> controller)
//   op      decoded sub-op (decoder -> controller)
//   nsel    one-hot register select [2] Rn, [1] Rd, [0] Rm (controller -> datapath)
//   vsel    one-hot write-back select [3] mdata, [2] sximm8, [1] PC, [0] C
//   loada/loadb/loadc/loads  datapath register enables
//   asel    1 selects zero as ALU operand A
//   bsel    1 selects sximm5 (never used by this controller)
//   write   register-file write enable
//   w       controller idle and ready for an instruction
//   ill     illegal-instruction flag, only with CPU_FSM_ILLEGAL_TRAP_EN
//
// Modports: master = decoder/datapath side, slave = cpu_fsm.
// Optional feature macro: CPU_FSM_ILLEGAL_TRAP_EN.
// ---------------------------------------------------------------------------
interface cpu_fsm_if;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       write;
    logic       w;
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
    logic       ill;
`endif

    modport master (
        output s, opcode, op,
        input  nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, w
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
        , input ill
`endif
    );

    modport slave (
        input  s, opcode, op,
        output nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, w
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
        , output ill
`endif
    );
endinterface

// File: rtl/cpu_fsm.sv
// ---------------------------------------------------------------------------
// cpu_fsm
// Moore controller for the Lab 6 CPU. Takes the decoded opcode/op and the
// start strobe and sequences register reads, the ALU step and write-back.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, forces WAIT
//   bus    cpu_fsm_if.slave (s/opcode/op in; nsel, vsel, load*, asel, bsel,
//          write, w and optionally ill out)
//
// Optional feature macro: CPU_FSM_ILLEGAL_TRAP_EN
//   defined   : illegal decode traps in HALT (ill = 1) until reset
//   undefined : illegal decode returns to WAIT as a no-op
// ---------------------------------------------------------------------------
module cpu_fsm (
    input  logic     clk,
    input  logic     rst_n,
    cpu_fsm_if.slave bus
);

    // The ALU step is split into three states so every output stays a pure
    // function of the state register, including asel and loads.
    typedef enum logic [3:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_ALU_ZERO_A,
        S_ALU_CMP,
        S_WRITE_REG,
        S_WRITE_IMM
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_e;

    localparam logic [4:0] INSTR_MOV_IMM = 5'b110_10;
    localparam logic [4:0] INSTR_MOV_REG = 5'b110_00;
    localparam logic [4:0] INSTR_ADD     = 5'b101_00;
    localparam logic [4:0] INSTR_CMP     = 5'b101_01;
    localparam logic [4:0] INSTR_AND     = 5'b101_10;
    localparam logic [4:0] INSTR_MVN     = 5'b101_11;

    state_e     state_q;
    state_e     state_d;
    logic [4:0] instr;

    assign instr = {bus.opcode, bus.op};

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. opcode/op are held by the instruction register, so
    // they are re-read in GET_B to pick the ALU flavour.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (bus.s) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (instr)
                    INSTR_MOV_IMM:                      state_d = S_WRITE_IMM;
                    INSTR_MOV_REG, INSTR_MVN:           state_d = S_GET_B;
                    INSTR_ADD, INSTR_CMP, INSTR_AND:    state_d = S_GET_A;
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
                    default:                            state_d = S_HALT;
`else
                    default:                            state_d = S_WAIT;
`endif
                endcase
            end
            S_GET_A: state_d = S_GET_B;
            S_GET_B: begin
                case (instr)
                    INSTR_MOV_REG, INSTR_MVN: state_d = S_ALU_ZERO_A;
                    INSTR_CMP:                state_d = S_ALU_CMP;
                    default:                  state_d = S_ALU;
                endcase
            end
            S_ALU:        state_d = S_WRITE_REG;
            S_ALU_ZERO_A: state_d = S_WRITE_REG;
            S_ALU_CMP:    state_d = S_WAIT;
            S_WRITE_REG:  state_d = S_WAIT;
            S_WRITE_IMM:  state_d = S_WAIT;
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
            S_HALT:       state_d = S_HALT;
`endif
            default:      state_d = S_WAIT;
        endcase
    end

    // Output decode from the state register only.
    always_comb begin
        bus.nsel  = 3'b000;
        bus.vsel  = 4'b0000;
        bus.loada = 1'b0;
        bus.loadb = 1'b0;
        bus.loadc = 1'b0;
        bus.loads = 1'b0;
        bus.asel  = 1'b0;
        bus.bsel  = 1'b0;
        bus.write = 1'b0;
        bus.w     = 1'b0;
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
        bus.ill   = 1'b0;
`endif
        case (state_q)
            S_WAIT: bus.w = 1'b1;
            S_GET_A: begin
                bus.nsel  = 3'b100;
                bus.loada = 1'b1;
            end
            S_GET_B: begin
                bus.nsel  = 3'b001;
                bus.loadb = 1'b1;
            end
            S_ALU: bus.loadc = 1'b1;
            S_ALU_ZERO_A: begin
                bus.loadc = 1'b1;
                bus.asel  = 1'b1;
            end
            S_ALU_CMP: begin
                bus.loadc = 1'b1;
                bus.loads = 1'b1;
            end
            S_WRITE_REG: begin
                bus.nsel  = 3'b010;
                bus.vsel  = 4'b0001;
                bus.write = 1'b1;
            end
            S_WRITE_IMM: begin
                bus.nsel  = 3'b100;
                bus.vsel  = 4'b0100;
                bus.write = 1'b1;
            end
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
            S_HALT: bus.ill = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_fsm.sv
// ---------------------------------------------------------------------------
// tb_cpu_fsm
// Randomized self-checking bench for cpu_fsm. Each issued instruction pushes
// an expected summary (busy cycles, enable pulse counts, write-back selects)
// into a queue; a monitor accumulates what the controller did between w
// falling and w rising and compares against the popped summary.
// Optional feature macro: CPU_FSM_ILLEGAL_TRAP_EN.
// ---------------------------------------------------------------------------
module tb_cpu_fsm;

    logic clk;
    logic rst_n;

    cpu_fsm_if bus ();

    cpu_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         busy;
        int         nA;
        int         nB;
        int         nC;
        int         nS;
        int         nW;
        logic       aselC;
        logic [3:0] vselW;
        logic [2:0] nselW;
    } exp_t;

    exp_t       expQ[$];
    int         checks;
    int         errors;
    int         idleDirty;
    int         bselSeen;
    logic [4:0] legalOps[6];

    // Count one comparison and report it if it does not hold.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic bit isLegal(input logic [2:0] opc, input logic [1:0] o);
        return (opc == 3'b110 && (o == 2'b10 || o == 2'b00)) || opc == 3'b101;
    endfunction

    // Reference model: what one instruction should do, from the ISA rules.
    function automatic exp_t modelFor(input logic [2:0] opc, input logic [1:0] o);
        exp_t e;
        bit   isMov;
        bit   isAlu;
        bit   zeroA;
        e     = '{default: 0};
        isMov = (opc == 3'b110);
        isAlu = (opc == 3'b101);
        if (isMov && o == 2'b10) begin
            e.busy  = 2;
            e.nW    = 1;
            e.vselW = 4'b0100;
            e.nselW = 3'b100;
        end else if ((isMov && o == 2'b00) || isAlu) begin
            zeroA   = isMov || (o == 2'b11);
            e.nA    = zeroA ? 0 : 1;
            e.nB    = 1;
            e.nC    = 1;
            e.aselC = zeroA;
            e.nS    = (isAlu && o == 2'b01) ? 1 : 0;
            e.nW    = 1 - e.nS;
            e.vselW = 4'b0001;
            e.nselW = 3'b010;
            e.busy  = 1 + e.nA + e.nB + e.nC + e.nW;
        end else begin
            e.busy = 1;
        end
        return e;
    endfunction

    // Monitor: accumulate one instruction's activity, compare when w returns.
    initial begin
        bit         active;
        int         busy, nA, nB, nC, nS, nW;
        logic       aselC;
        logic [3:0] vselW;
        logic [2:0] nselW;
        exp_t       e;
        active = 0;
        busy = 0; nA = 0; nB = 0; nC = 0; nS = 0; nW = 0;
        aselC = 0; vselW = 0; nselW = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0;
                continue;
            end
            if (bus.bsel !== 1'b0) bselSeen++;
            if (bus.w === 1'b0) begin
                if (!active) begin
                    active = 1;
                    busy = 0; nA = 0; nB = 0; nC = 0; nS = 0; nW = 0;
                    aselC = 0; vselW = 0; nselW = 0;
                end
                busy++;
                if (bus.loada) begin
                    nA++;
                    checkOutput("nsel_at_loada", 32'(bus.nsel), 32'(3'b100));
                end
                if (bus.loadb) begin
                    nB++;
                    checkOutput("nsel_at_loadb", 32'(bus.nsel), 32'(3'b001));
                end
                if (bus.loadc) begin
                    nC++;
                    aselC = bus.asel;
                end
                if (bus.loads) nS++;
                if (bus.write) begin
                    nW++;
                    vselW = bus.vsel;
                    nselW = bus.nsel;
                end
            end else begin
                if (bus.loada || bus.loadb || bus.loadc || bus.loads || bus.write ||
                    bus.asel || bus.nsel != 3'b000 || bus.vsel != 4'b0000)
                    idleDirty++;
                if (active) begin
                    active = 0;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_instr", 32'(busy), 32'(0));
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("busy_cycles", 32'(busy), 32'(e.busy));
                        checkOutput("loada_count", 32'(nA), 32'(e.nA));
                        checkOutput("loadb_count", 32'(nB), 32'(e.nB));
                        checkOutput("loadc_count", 32'(nC), 32'(e.nC));
                        checkOutput("loads_count", 32'(nS), 32'(e.nS));
                        checkOutput("write_count", 32'(nW), 32'(e.nW));
                        if (e.nC > 0) checkOutput("asel_at_loadc", 32'(aselC), 32'(e.aselC));
                        if (e.nW > 0) begin
                            checkOutput("vsel_at_write", 32'(vselW), 32'(e.vselW));
                            checkOutput("nsel_at_write", 32'(nselW), 32'(e.nselW));
                        end
                    end
                end
            end
        end
    end

    // Wait (bounded) until the controller reports idle.
    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (bus.w !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.w !== 1'b1) checkOutput(tag, 32'(bus.w), 32'(1));
    endtask

    // Issue one instruction; s is randomized while busy since it must be ignored.
    task automatic applyStimulus(input logic [2:0] opc, input logic [1:0] o);
        exp_t e;
        int   gap;
        e = modelFor(opc, o);
        waitIdle("timeout_idle_before");
        bus.opcode = opc;
        bus.op     = o;
        expQ.push_back(e);
        bus.s = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < e.busy; k++) begin
            bus.s = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        bus.s = 1'b0;
        waitIdle("timeout_idle_after");
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // s held high across the return to WAIT starts the next instruction at once.
    task automatic applyBackToBack();
        exp_t e;
        e = modelFor(3'b101, 2'b01);
        waitIdle("timeout_b2b_before");
        bus.opcode = 3'b101;
        bus.op     = 2'b01;
        expQ.push_back(e);
        expQ.push_back(e);
        bus.s = 1'b1;
        @(posedge clk);
        #1;
        repeat (e.busy) begin
            @(posedge clk);
            #1;
        end
        checkOutput("b2b_gap_w", 32'(bus.w), 32'(1));
        @(posedge clk);
        #1;
        checkOutput("b2b_restart_w", 32'(bus.w), 32'(0));
        bus.s = 1'b0;
        waitIdle("timeout_b2b_after");
    endtask

    // Reset dropped while an ADD is in GET_B.
    task automatic applyAbort();
        waitIdle("timeout_abort_before");
        bus.opcode = 3'b101;
        bus.op     = 2'b00;
        bus.s      = 1'b1;
        @(posedge clk);
        #1;
        bus.s = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("abort_loadb_before", 32'(bus.loadb), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_loadb_after", 32'(bus.loadb), 32'(0));
        checkOutput("abort_w", 32'(bus.w), 32'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_write", 32'(bus.write), 32'(0));
            checkOutput("abort_idle_w", 32'(bus.w), 32'(1));
        end
    endtask

`ifdef CPU_FSM_ILLEGAL_TRAP_EN
    // Illegal decode must trap until reset, regardless of s.
    task automatic applyHalt();
        waitIdle("timeout_halt_before");
        bus.opcode = 3'b000;
        bus.op     = 2'b00;
        bus.s      = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            bus.s = 1'b1;
            @(posedge clk);
            #1;
            bus.s = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("halt_ill", 32'(bus.ill), 32'(1));
            checkOutput("halt_w", 32'(bus.w), 32'(0));
            checkOutput("halt_enables", 32'({bus.loada, bus.loadb, bus.loadc,
                        bus.loads, bus.write, bus.nsel, bus.vsel}), 32'(0));
        end
        rst_n = 1'b0;
        #1;
        checkOutput("halt_reset_ill", 32'(bus.ill), 32'(0));
        checkOutput("halt_reset_w", 32'(bus.w), 32'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0] code;
        checks    = 0;
        errors    = 0;
        idleDirty = 0;
        bselSeen  = 0;
        legalOps  = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_01, 5'b101_10, 5'b101_11};
        bus.s      = 1'b0;
        bus.opcode = 3'b000;
        bus.op     = 2'b00;
        rst_n      = 1'b0;

        repeat (2) begin
            bus.s = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            checkOutput("reset_w", 32'(bus.w), 32'(1));
            checkOutput("reset_enables", 32'({bus.nsel, bus.vsel, bus.loada, bus.loadb,
                        bus.loadc, bus.loads, bus.asel, bus.bsel, bus.write}), 32'(0));
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
            checkOutput("reset_ill", 32'(bus.ill), 32'(0));
`endif
        end
        bus.s = 1'b0;
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            checkOutput("idle_after_reset_w", 32'(bus.w), 32'(1));
        end

        applyStimulus(3'b110, 2'b10);
        applyStimulus(3'b110, 2'b00);
        applyStimulus(3'b101, 2'b00);
        applyStimulus(3'b101, 2'b01);
        applyStimulus(3'b101, 2'b10);
        applyStimulus(3'b101, 2'b11);
`ifndef CPU_FSM_ILLEGAL_TRAP_EN
        applyStimulus(3'b000, 2'b00);
`endif
        applyBackToBack();
        applyAbort();
        applyStimulus(3'b101, 2'b00);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) code = legalOps[$urandom_range(0, 5)];
            else code = 5'($urandom_range(0, 31));
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
            if (!isLegal(code[4:2], code[1:0])) code = legalOps[$urandom_range(0, 5)];
`endif
            applyStimulus(code[4:2], code[1:0]);
        end

`ifdef CPU_FSM_ILLEGAL_TRAP_EN
        applyHalt();
        applyStimulus(3'b110, 2'b10);
`endif

        @(negedge clk);
        @(negedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'(0));
        checkOutput("idle_outputs_clean", 32'(idleDirty), 32'(0));
        checkOutput("bsel_never_set", 32'(bselSeen), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
